psum_drain: RTL

- Consumer end of a PE column: captures `output_sum` of the last PE in a 1-D convolution chain, a fixed latency after each ifmap sample injected upstream.
- Discards warm-up windows, requantizes the 32-bit partial sum to int8 (rounding shift, optional ReLU, saturation) and buffers results in a FIFO for the ofmap writer.
- PE chain cannot stall, so the block issues a credit signal (`accept_ok`) that gates upstream sample injection.

---
 rtl/psum_drain.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/psum_drain.sv
// Drain stage at the tail of a PE column: tracks which PE outputs are real via a tag
// delay line, requantizes them to int8 and queues them for the ofmap writer with credit flow control.
module psum_drain #(
   parameter int unsigned KERNEL_W   = 3,
   parameter int unsigned PIPE_LAT   = 5,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sample_fire,
   input  logic               sample_last,
   input  logic signed [31:0] pe_sum,
   input  logic        [4:0]  shift_amt,
   input  logic               relu_en,
   output logic               accept_ok,
   output logic signed [7:0]  out_data,
   output logic               out_valid,
   output logic               out_last,
   input  logic               out_ready,
   output logic               overflow_err
);
   localparam int unsigned CW = $clog2(KERNEL_W) + 1;
   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned NW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned IW = $clog2(PIPE_LAT + 1);
   localparam int unsigned SW = ((NW > IW) ? NW : IW) + 1;

   logic [CW-1:0]       cnt;
   logic                producing;
   logic                prod_fire;
   logic [PIPE_LAT-1:0] tag_v;
   logic [PIPE_LAT-1:0] tag_l;
   logic                cap_v;
   logic                cap_l;
   logic [IW-1:0]       inflight;

   logic signed [32:0]  ext;
   logic signed [32:0]  rnd;
   logic signed [32:0]  v;
   logic signed [7:0]   q;

   logic [8:0]          mem [FIFO_DEPTH];
   logic [AW-1:0]       wptr;
   logic [AW-1:0]       rptr;
   logic [NW-1:0]       count;
   logic                full;
   logic                pop;
   logic                push_ok;

   assign producing = (cnt >= CW'(KERNEL_W - 1));
   assign prod_fire = sample_fire & producing;
   assign cap_v     = tag_v[PIPE_LAT-1];
   assign cap_l     = tag_l[PIPE_LAT-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (sample_fire) begin
         if (sample_last)
            cnt <= '0;
         else if (!producing)
            cnt <= cnt + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tag_v <= '0;
         tag_l <= '0;
      end else begin
         tag_v[0] <= prod_fire;
         tag_l[0] <= prod_fire & sample_last;
         for (int unsigned i = 1; i < PIPE_LAT; i++) begin
            tag_v[i] <= tag_v[i-1];
            tag_l[i] <= tag_l[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         inflight <= '0;
      else if (prod_fire && !cap_v)
         inflight <= inflight + IW'(1);
      else if (!prod_fire && cap_v)
         inflight <= inflight - IW'(1);
   end

   // Rounding add cannot overflow 33 bits: |pe_sum| < 2^31 and the bias is at most 2^30.
   always_comb begin
      ext = {pe_sum[31], pe_sum};
      rnd = '0;
      v   = ext;
      if (shift_amt != '0) begin
         rnd = 33'sd1 <<< (shift_amt - 5'd1);
         v   = (ext + rnd) >>> shift_amt;
      end
      if (relu_en && v[32])
         v = '0;
      if (v > 33'sd127)
         q = 8'sd127;
      else if (v < -33'sd128)
         q = -8'sd128;
      else
         q = v[7:0];
   end

   assign full    = (count == NW'(FIFO_DEPTH));
   assign pop     = out_valid & out_ready;
   assign push_ok = cap_v & (~full | pop);

   // When full with a pop, wptr == rptr: the head has already been presented this cycle.
   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wptr] <= {cap_l, q};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr         <= '0;
         rptr         <= '0;
         count        <= '0;
         overflow_err <= 1'b0;
      end else begin
         if (push_ok)
            wptr <= wptr + AW'(1);
         if (pop)
            rptr <= rptr + AW'(1);
         if (push_ok && !pop)
            count <= count + NW'(1);
         else if (!push_ok && pop)
            count <= count - NW'(1);
         if (cap_v && full && !pop)
            overflow_err <= 1'b1;
      end
   end

   assign out_valid = (count != '0);
   assign out_data  = out_valid ? $signed(mem[rptr][7:0]) : '0;
   assign out_last  = out_valid ? mem[rptr][8] : 1'b0;
   assign accept_ok = (SW'(count) + SW'(inflight)) < SW'(FIFO_DEPTH);

endmodule
